btn_conditioner: RTL and testbench

Input-conditioning stage in front of the car control FSM. Synchronises, debounces and classifies the raw board push-buttons and switches (power-on/off, throttle, clutch, turn, barrier) into clean levels, one-cycle edge strobes and a 1 s long-press flag. The FSM and the power-on logic consume these outputs instead of raw pins. All channels are independent and share a single millisecond tick generator.

---
 rtl/btn_cond_pkg.sv | 17 +
 rtl/btn_conditioner_channel.sv | 175 +++++++++++++++++
 rtl/btn_conditioner.sv | 54 +++++
 tb/tb_btn_conditioner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and default constants for the button conditioner.
// Optional feature macro: LONG_PRESS_EN (long-press hold counter).
package btn_cond_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_CHK,
      HELD,
      LONG,
      REL_CHK
   } btn_state_e;

   localparam int unsigned TICK_DIV_DEF    = 100000;
   localparam int unsigned DEBOUNCE_MS_DEF = 20;
   localparam int unsigned LONG_MS_DEF     = 1000;

endpackage

// File: rtl/btn_conditioner_channel.sv
// One button channel: two-flop synchroniser, debounce FSM, hold counter.
// LONG_PRESS_EN builds the hold counter and the LONG state.
module btn_channel
   import btn_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
   parameter int unsigned LONG_MS     = LONG_MS_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic long_o
);

   localparam int unsigned DBW = $clog2(DEBOUNCE_MS);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_MS - 1);

   if (DEBOUNCE_MS < 2 || LONG_MS <= DEBOUNCE_MS) begin : g_cfg_err
      $error("btn_channel: DEBOUNCE_MS must be >= 2 and < LONG_MS");
   end

   logic [1:0]     sync_q;
   logic           sync;
   btn_state_e     state_q, state_d;
   logic [DBW-1:0] db_cnt_q, db_cnt_d;
   logic           level_q, level_d;
   logic           rise_q, rise_d;
   logic           fall_q, fall_d;

`ifdef LONG_PRESS_EN
   localparam int unsigned HW = $clog2(LONG_MS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);

   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          long_q, long_d;
`endif

   assign sync = sync_q[1];

   // Bring the raw pin into the clock domain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], raw_i};
      end
   end

   // Next state: a sync change always beats a tick in the same cycle.
   always_comb begin
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
`ifdef LONG_PRESS_EN
      hold_cnt_d = hold_cnt_q;
      long_d     = long_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (sync) begin
               state_d  = PRESS_CHK;
               db_cnt_d = '0;
            end
         end
         PRESS_CHK: begin
            if (!sync) begin
               state_d = IDLE;
            end else if (tick_i) begin
               if (db_cnt_q == DB_LAST) begin
                  state_d = HELD;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
`ifdef LONG_PRESS_EN
                  hold_cnt_d = '0;
`endif
               end else begin
                  db_cnt_d = db_cnt_q + 1'b1;
               end
            end
         end
         HELD: begin
            if (!sync) begin
               state_d  = REL_CHK;
               db_cnt_d = '0;
            end
`ifdef LONG_PRESS_EN
            else if (tick_i) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d = LONG;
                  long_d  = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
`endif
         end
`ifdef LONG_PRESS_EN
         LONG: begin
            if (!sync) begin
               state_d  = REL_CHK;
               db_cnt_d = '0;
            end
         end
`endif
         REL_CHK: begin
            if (sync) begin
`ifdef LONG_PRESS_EN
               state_d = long_q ? LONG : HELD;
`else
               state_d = HELD;
`endif
            end else if (tick_i) begin
               if (db_cnt_q == DB_LAST) begin
                  state_d = IDLE;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
`ifdef LONG_PRESS_EN
                  long_d = 1'b0;
`endif
               end else begin
                  db_cnt_d = db_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         db_cnt_q <= '0;
         level_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

`ifdef LONG_PRESS_EN
   // Hold counter and long-press flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         long_q     <= long_d;
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button/switch conditioner: shared ms tick plus N_BTN debounced channels.
// Optional feature macro: LONG_PRESS_EN (long-press flag on btn_long).
module btn_conditioner
   import btn_cond_pkg::*;
#(
   parameter int unsigned N_BTN       = 8,
   parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
   parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
   parameter int unsigned LONG_MS     = LONG_MS_DEF
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall,
   output logic [N_BTN-1:0] btn_long
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;

   assign tick       = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   // Millisecond prescaler; tick is high in the cycle it wraps.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .LONG_MS     (LONG_MS)
      ) u_ch (
         .clk_i   (sys_clk),
         .rst_ni  (rst_n),
         .tick_i  (tick),
         .raw_i   (btn_raw[i]),
         .level_o (btn_level[i]),
         .rise_o  (btn_rise[i]),
         .fall_o  (btn_fall[i]),
         .long_o  (btn_long[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised self-checking bench for btn_conditioner.
// Reference model: level flips once a differing input survives DB ticks.
module tb_btn_conditioner;

   localparam int N  = 8;
   localparam int TD = 10;
   localparam int DB = 4;
   localparam int LG = 20;
`ifdef LONG_PRESS_EN
   localparam bit LONG_ON = 1'b1;
`else
   localparam bit LONG_ON = 1'b0;
`endif

   logic         sys_clk = 1'b0;
   logic         rst_n   = 1'b0;
   logic [N-1:0] btn_raw = '0;
   logic [N-1:0] btn_level, btn_rise, btn_fall, btn_long;

   always #5 sys_clk = ~sys_clk;

   btn_conditioner #(
      .N_BTN       (N),
      .TICK_DIV    (TD),
      .DEBOUNCE_MS (DB),
      .LONG_MS     (LG)
   ) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_rise  (btn_rise),
      .btn_fall  (btn_fall),
      .btn_long  (btn_long)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc_no = 0;

   logic [N-1:0] m_s1, m_s2, m_lvl, m_lng, m_rise, m_fall;
   bit           m_run [N];
   int           m_tc  [N];
   int           m_hc  [N];
   int           m_tick_n;

   int           rise_cyc [N];
   int           rise_cnt [N];
   int           fall_cnt [N];
   int           long_cyc [N];
   logic [N-1:0] prev_long;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h",
                  tag, cyc_no, got, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lng = '0;
      m_rise = '0; m_fall = '0; m_tick_n = 0;
      for (int i = 0; i < N; i++) begin
         m_run[i] = 1'b0; m_tc[i] = 0; m_hc[i] = 0;
      end
   endtask

   task automatic model_step();
      logic [N-1:0] sync;
      bit           tick;
      m_tick_n++;
      tick = (m_tick_n % TD) == 0;
      sync = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
         if (sync[i] != m_lvl[i]) begin
            if (!m_run[i]) begin
               m_run[i] = 1'b1;
               m_tc[i]  = 0;
            end else if (tick) begin
               m_tc[i]++;
               if (m_tc[i] == DB) begin
                  m_run[i] = 1'b0;
                  m_lvl[i] = sync[i];
                  if (sync[i]) begin
                     m_rise[i] = 1'b1;
                     m_hc[i]   = 0;
                  end else begin
                     m_fall[i] = 1'b1;
                     m_lng[i]  = 1'b0;
                  end
               end
            end
         end else begin
            if (LONG_ON && m_lvl[i] && !m_run[i] && tick && !m_lng[i]) begin
               m_hc[i]++;
               if (m_hc[i] == LG) m_lng[i] = 1'b1;
            end
            m_run[i] = 1'b0;
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         cyc_no++;
         if (rst_n) model_step();
         else model_reset();
         #1;
         check_eq("level", 32'(btn_level), 32'(m_lvl));
         check_eq("rise",  32'(btn_rise),  32'(m_rise));
         check_eq("fall",  32'(btn_fall),  32'(m_fall));
         check_eq("long",  32'(btn_long),  32'(m_lng));
         for (int i = 0; i < N; i++) begin
            if (btn_rise[i]) begin
               rise_cyc[i] = cyc_no;
               rise_cnt[i]++;
            end
            if (btn_fall[i]) fall_cnt[i]++;
            if (btn_long[i] && !prev_long[i]) long_cyc[i] = cyc_no;
         end
         prev_long = btn_long;
      end
   endtask

   initial begin
      int t0;
      int rc;
      model_reset();
      prev_long = '0;
      for (int i = 0; i < N; i++) begin
         rise_cyc[i] = -1; rise_cnt[i] = 0;
         fall_cnt[i] = 0;  long_cyc[i] = -1;
      end

      repeat (3) @(posedge sys_clk);
      #1;
      check_eq("rst_level", 32'(btn_level), 0);
      check_eq("rst_rise",  32'(btn_rise),  0);
      check_eq("rst_fall",  32'(btn_fall),  0);
      check_eq("rst_long",  32'(btn_long),  0);
      rst_n = 1'b1;
      cyc(5);

      // clean press on bit 0
      t0 = cyc_no;
      btn_raw[0] = 1'b1;
      cyc(60);
      check_eq("b0_rise_once", rise_cnt[0], 1);
      check_eq("b0_latency_win",
               32'((rise_cyc[0] - t0 >= 33) && (rise_cyc[0] - t0 <= 44)), 1);
      check_eq("b0_level", 32'(btn_level[0]), 1);
      check_eq("b0_others", 32'(btn_level[7:1]), 0);

      // 25-cycle glitch on bit 1
      btn_raw[1] = 1'b1;
      cyc(25);
      btn_raw[1] = 1'b0;
      cyc(40);
      check_eq("b1_no_rise", rise_cnt[1], 0);
      check_eq("b1_level", 32'(btn_level[1]), 0);

      // bits 4 and 5 together
      btn_raw[5:4] = 2'b11;
      cyc(60);
      check_eq("b4_rise", rise_cnt[4], 1);
      check_eq("b5_rise", rise_cnt[5], 1);
      check_eq("b45_same_cyc", rise_cyc[4], rise_cyc[5]);

      // long hold on bit 2, bounce, release
      btn_raw[2] = 1'b1;
      for (int k = 0; k < 100 && rise_cnt[2] == 0; k++) cyc(1);
      check_eq("b2_rise_seen", rise_cnt[2], 1);
      cyc(240);
`ifdef LONG_PRESS_EN
      check_eq("b2_long_win",
               32'((long_cyc[2] - rise_cyc[2] >= 190) &&
                   (long_cyc[2] - rise_cyc[2] <= 200)), 1);
      check_eq("b2_long", 32'(btn_long[2]), 1);
`else
      check_eq("b2_long_off", 32'(btn_long[2]), 0);
`endif
      btn_raw[2] = 1'b0;
      cyc(15);
      btn_raw[2] = 1'b1;
      cyc(50);
      check_eq("b2_bounce_nofall", fall_cnt[2], 0);
      check_eq("b2_bounce_level", 32'(btn_level[2]), 1);
      check_eq("b2_bounce_long", 32'(btn_long[2]), 32'(LONG_ON));
      btn_raw[2] = 1'b0;
      cyc(60);
      check_eq("b2_fall", fall_cnt[2], 1);
      check_eq("b2_rel_level", 32'(btn_level[2]), 0);
      check_eq("b2_rel_long", 32'(btn_long[2]), 0);

      // reset mid-hold on bit 3
      btn_raw[3] = 1'b1;
      for (int k = 0; k < 100 && rise_cnt[3] == 0; k++) cyc(1);
      check_eq("b3_rise_seen", rise_cnt[3], 1);
      cyc(30);
      rst_n = 1'b0;
      #1;
      check_eq("async_level", 32'(btn_level), 0);
      check_eq("async_long",  32'(btn_long),  0);
      model_reset();
      cyc(3);
      rc = rise_cnt[3];
      t0 = cyc_no;
      rst_n = 1'b1;
      cyc(60);
      check_eq("b3_rerise", rise_cnt[3], rc + 1);
      check_eq("b3_full_db", rise_cyc[3] - t0, DB * TD);

      // random bouncing on all channels
      btn_raw = '0;
      cyc(60);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, (c < 1500) ? 29 : 119) == 0)
               btn_raw[i] = ~btn_raw[i];
         end
         if (c == 1800) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_eq("rnd_rst_level", 32'(btn_level), 0);
            cyc(2);
            rst_n = 1'b1;
         end
         cyc(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
